// File: rtl/la_ram_write_arbiter_if.sv
//------------------------------------------------------------------------------
// la_ram_write_arbiter_if
//
// Bundles the client write streams and the memory-controller write port of
// the logic-analyzer DRAM write arbiter.
//
// Signals:
//   wr_en        per-channel write request (level, held until acked)
//   wr_addr      flattened client addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   wr_data      flattened client data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_ack       per-channel one-cycle capture pulse
//   mem_wr_en    write valid towards the memory controller
//   mem_wr_addr  write address towards the memory controller
//   mem_wr_data  write data towards the memory controller
//   mem_wr_ready controller accepts the beat when high together with mem_wr_en
//   mem_wr_chan  source channel of the beat currently presented
//
// Modports:
//   master  environment side: capture clients plus memory controller
//   slave   arbiter side
//------------------------------------------------------------------------------
interface la_ram_write_arbiter_if #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 128,
  parameter int CHAN_WIDTH = $clog2(NUM_CH)
);

  logic [NUM_CH-1:0]            wr_en;
  logic [NUM_CH*ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_CH*DATA_WIDTH-1:0] wr_data;
  logic [NUM_CH-1:0]            wr_ack;
  logic                         mem_wr_en;
  logic [ADDR_WIDTH-1:0]        mem_wr_addr;
  logic [DATA_WIDTH-1:0]        mem_wr_data;
  logic                         mem_wr_ready;
  logic [CHAN_WIDTH-1:0]        mem_wr_chan;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output mem_wr_ready,
    input  wr_ack,
    input  mem_wr_en,
    input  mem_wr_addr,
    input  mem_wr_data,
    input  mem_wr_chan
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  mem_wr_ready,
    output wr_ack,
    output mem_wr_en,
    output mem_wr_addr,
    output mem_wr_data,
    output mem_wr_chan
  );

endinterface

// File: rtl/la_ram_write_arbiter.sv
//------------------------------------------------------------------------------
// la_ram_write_arbiter
//
// Merges NUM_CH logic-analyzer capture write streams onto a single
// memory-controller write port in the clk_ram domain. Arbitration is
// round-robin with a burst hold of up to MAX_BURST consecutive beats per
// channel, channels can be masked out with chan_enable, and every channel
// has a saturating accepted-beat counter for capture diagnostics.
//
// Ports:
//   clk_ram      sole clock
//   rst_n        asynchronous active-low reset
//   chan_enable  per-channel arbitration eligibility
//   bus          client streams + memory write port (slave modport)
//   stats_clear  synchronous clear of all beat counters (wins over increment)
//   beat_count   flattened saturating counters, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//
// Operating states follow directly from the output register:
//   IDLE   mem_wr_en=0
//   HOLD   mem_wr_en=1 while mem_wr_ready=0, beat frozen
//   STREAM beat accepted and a new one loaded in the same cycle
//------------------------------------------------------------------------------
module la_ram_write_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 128,
  parameter int MAX_BURST  = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                        clk_ram,
  input  logic                        rst_n,
  input  logic [NUM_CH-1:0]           chan_enable,
  la_ram_write_arbiter_if.slave       bus,
  input  logic                        stats_clear,
  output logic [NUM_CH*CNT_WIDTH-1:0] beat_count
);

  localparam int               CHAN_WIDTH  = $clog2(NUM_CH);
  localparam logic [7:0]       MAX_BURST_C = 8'(MAX_BURST);
  localparam logic [CHAN_WIDTH-1:0] LAST_CH = CHAN_WIDTH'(NUM_CH - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};

  // Combinational arbitration signals
  logic [NUM_CH-1:0]     eligible_s;
  logic                  load_s;
  logic                  accept_s;
  logic                  keep_owner_s;
  logic [CHAN_WIDTH-1:0] sel_s;
  logic [7:0]            burst_next_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_data_s;

  // Output register and arbitration state
  logic                  mem_wr_en_r;
  logic [ADDR_WIDTH-1:0] mem_wr_addr_r;
  logic [DATA_WIDTH-1:0] mem_wr_data_r;
  logic [CHAN_WIDTH-1:0] mem_wr_chan_r;
  logic [CHAN_WIDTH-1:0] owner_r;
  logic [7:0]            burst_cnt_r;
  logic [NUM_CH-1:0][CNT_WIDTH-1:0] beat_cnt_r;

  assign eligible_s = bus.wr_en & chan_enable;
  assign accept_s   = mem_wr_en_r & bus.mem_wr_ready;

  // A new beat may enter the output register when it is empty or draining.
  // rst_n gates the load so no ack can escape while reset is held.
  assign load_s = rst_n & (~mem_wr_en_r | bus.mem_wr_ready) & (|eligible_s);

  // Burst hold: burst_cnt_r==0 means no channel holds ownership yet (after
  // reset), so the first grant comes from the rotating scan starting at ch0.
  assign keep_owner_s = eligible_s[owner_r] &
                        (burst_cnt_r != 8'd0) &
                        (burst_cnt_r < MAX_BURST_C);

  // Channel selection: keep the owner inside its burst budget, otherwise scan
  // owner+1 .. owner+NUM_CH so the owner is considered last.
  always_comb begin
    int   idx_v;
    logic found_v;
    sel_s        = owner_r;
    burst_next_s = 8'd1;
    idx_v        = 0;
    found_v      = 1'b0;
    if (keep_owner_s) begin
      sel_s        = owner_r;
      burst_next_s = burst_cnt_r + 8'd1;
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        idx_v = (int'(owner_r) + k) % NUM_CH;
        if (!found_v && eligible_s[idx_v]) begin
          sel_s   = CHAN_WIDTH'(idx_v);
          found_v = 1'b1;
        end else begin
          found_v = found_v;
        end
      end
    end
  end

  // Address/data multiplexer for the selected channel
  always_comb begin
    sel_addr_s = {ADDR_WIDTH{1'b0}};
    sel_data_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_s == CHAN_WIDTH'(i)) begin
        sel_addr_s = bus.wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data_s = bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sel_addr_s = sel_addr_s;
        sel_data_s = sel_data_s;
      end
    end
  end

  // Capture acknowledge: one-hot on the selected channel in the load cycle
  always_comb begin
    bus.wr_ack = {NUM_CH{1'b0}};
    if (load_s) begin
      bus.wr_ack[sel_s] = 1'b1;
    end else begin
      bus.wr_ack = {NUM_CH{1'b0}};
    end
  end

  // Output register, ownership and burst tracking
  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_en_r   <= 1'b0;
      mem_wr_addr_r <= {ADDR_WIDTH{1'b0}};
      mem_wr_data_r <= {DATA_WIDTH{1'b0}};
      mem_wr_chan_r <= {CHAN_WIDTH{1'b0}};
      owner_r       <= LAST_CH;
      burst_cnt_r   <= 8'd0;
    end else if (load_s) begin
      mem_wr_en_r   <= 1'b1;
      mem_wr_addr_r <= sel_addr_s;
      mem_wr_data_r <= sel_data_s;
      mem_wr_chan_r <= sel_s;
      owner_r       <= sel_s;
      burst_cnt_r   <= burst_next_s;
    end else if (accept_s) begin
      // Beat drained with nothing to replace it; payload left as is
      mem_wr_en_r   <= 1'b0;
    end else begin
      mem_wr_en_r   <= mem_wr_en_r;
    end
  end

  // Saturating per-channel accepted-beat counters; clear wins over increment
  always_ff @(posedge clk_ram or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r <= {(NUM_CH*CNT_WIDTH){1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (stats_clear) begin
          beat_cnt_r[i] <= {CNT_WIDTH{1'b0}};
        end else if (accept_s && (mem_wr_chan_r == CHAN_WIDTH'(i)) &&
                     (beat_cnt_r[i] != CNT_MAX)) begin
          beat_cnt_r[i] <= beat_cnt_r[i] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          beat_cnt_r[i] <= beat_cnt_r[i];
        end
      end
    end
  end

  assign bus.mem_wr_en   = mem_wr_en_r;
  assign bus.mem_wr_addr = mem_wr_addr_r;
  assign bus.mem_wr_data = mem_wr_data_r;
  assign bus.mem_wr_chan = mem_wr_chan_r;
  assign beat_count      = beat_cnt_r;

endmodule

// File: doc/la_ram_write_arbiter.md
Name: la_ram_write_arbiter

Overview:
- N-channel successor to the fixed two-pod (la0/la1) DRAM write path.
- Merges NUM_CH logic-analyzer capture write streams onto one memory-controller write port in the clk_ram domain.
- Arbitration is round-robin with a configurable burst hold, per-channel enable masking, and saturating per-channel beat counters for capture diagnostics.

Parameters:
- NUM_CH, 4, number of client channels (2..8).
- ADDR_WIDTH, 29, client/memory address width.
- DATA_WIDTH, 128, client/memory data width.
- MAX_BURST, 8, max consecutive beats granted to one channel while others request (1..255).
- CNT_WIDTH, 32, width of each per-channel beat counter.

Ports:
- clk_ram  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- chan_enable  in  NUM_CH  per-channel arbitration eligibility.
- wr_en  in  NUM_CH  per-channel write request, level; held with addr/data until acked.
- wr_addr  in  NUM_CH*ADDR_WIDTH  flattened; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- wr_data  in  NUM_CH*DATA_WIDTH  flattened likewise.
- wr_ack  out  NUM_CH  one-cycle pulse; beat captured this cycle.
- mem_wr_en  out  1  registered write valid to controller.
- mem_wr_addr  out  ADDR_WIDTH  registered address.
- mem_wr_data  out  DATA_WIDTH  registered data.
- mem_wr_ready  in  1  controller accepts the beat when high with mem_wr_en.
- mem_wr_chan  out  $clog2(NUM_CH)  source channel of the current output beat.
- stats_clear  in  1  synchronous clear of all beat counters.
- beat_count  out  NUM_CH*CNT_WIDTH  saturating accepted-beat count per channel.

Behaviour:
- Reset values (async, rst_n low): mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0, mem_wr_chan=0, wr_ack=0, beat_count=0, owner=NUM_CH-1, burst_cnt=0.
- Reset mid-transfer drops any beat held in the output register; it is never acked twice and is not counted.
- Output register holds one beat. load = (!mem_wr_en || mem_wr_ready) && |(wr_en & chan_enable).
- The beat is accepted when mem_wr_en && mem_wr_ready. Without a new load in that cycle, mem_wr_en goes 0 next cycle.
- When mem_wr_en=1 and mem_wr_ready=0, mem_wr_addr, mem_wr_data and mem_wr_chan stay stable.
- Selection on load, with eligible = wr_en & chan_enable:
  - If eligible[owner] and burst_cnt < MAX_BURST: select owner, burst_cnt += 1.
  - Otherwise select the first eligible channel scanning owner+1, owner+2, ... modulo NUM_CH (owner itself is checked last). Set owner to it, burst_cnt = 1.
  - If owner is the only eligible channel, it is selected even at MAX_BURST, with burst_cnt reset to 1. No idle bubble is inserted.
- wr_ack[sel] is combinational: high in the load cycle only, at most one bit set. The client must present its next beat (or drop wr_en) in the following cycle.
- Throughput: one beat per clock when mem_wr_ready stays high; back-to-back beats from the same channel are allowed.
- Latency: wr_en sampled at edge T means mem_wr_en is high after edge T, provided the output register is free or draining.
- chan_enable deasserted: the channel is ineligible from that cycle on. A beat already in the output register still completes. Ownership is released at the next load.
- Request states: IDLE (mem_wr_en=0), HOLD (mem_wr_en=1, waiting on ready), STREAM (accept+load in the same cycle). The FSM is derived from mem_wr_en and load; no extra state is needed.
- beat_count[i] increments on accept when mem_wr_chan==i and saturates at all-ones.
- stats_clear has priority over an increment in the same cycle; the result is 0.
- Client wr_en dropping without an ack is a protocol violation; the behaviour is unspecified apart from no lockup.

Test Plan:
- Single channel streaming: ch0 requests 20 beats, addr 0x100..0x113, mem_wr_ready=1 → 20 consecutive mem_wr_en cycles, addresses in order, wr_ack[0] on 20 cycles, beat_count[0]=20.
- Round-robin with burst: all 4 channels request continuously, MAX_BURST=8 → mem_wr_chan sequence 0×8, 1×8, 2×8, 3×8, 0×8. No gaps.
- Backpressure: mem_wr_ready low for 5 cycles mid-stream → mem_wr_addr/data/chan frozen, no wr_ack during the stall; resumes with no beat lost or duplicated.
- Enable mask: chan_enable=4'b1011 with ch2 requesting → ch2 never acked. Setting bit 2 → ch2 is served within 3*MAX_BURST+1 cycles.
- Counter edges: CNT_WIDTH=4, 18 ch1 beats → beat_count[1]=15. stats_clear asserted on an accept cycle → 0 next cycle.
- Async reset mid-HOLD: rst_n low with mem_wr_en=1, ready=0 → mem_wr_en=0 immediately. After release, ch0 is served first when all channels request.
